// File: rtl/duty_pid_compensator_pkg.sv
// ----------------------------------------------------------------------------
// duty_pid_compensator_pkg
//   Shared constants and helpers for the closed-loop duty path and the
//   DPWM/frequency path.
//   - ERR_W, DUTY_W         : error sample width, duty/maxcount width
//   - COEF_W, FRAC_BITS     : coefficient width, accumulator fraction bits
//   - ACC_W                 : signed accumulator width
//   - A0_DEF..A2_DEF        : default incremental-PID coefficients
//   - pid_state_t           : compensator sequencing states
//   - sat_add()             : ACC_W-wide signed add that saturates instead of wrapping
// ----------------------------------------------------------------------------
package duty_pid_compensator_pkg;

    localparam int ERR_W     = 13;
    localparam int DUTY_W    = 10;
    localparam int COEF_W    = 12;
    localparam int FRAC_BITS = 4;
    localparam int ACC_W     = 26;
    localparam int PROD_W    = COEF_W + ERR_W;
    // Integer part of the accumulator, i.e. the unclamped duty candidate.
    localparam int CAND_W    = ACC_W - FRAC_BITS;

    localparam logic signed [COEF_W-1:0] A0_DEF = 12'sd16;
    localparam logic signed [COEF_W-1:0] A1_DEF = -12'sd12;
    localparam logic signed [COEF_W-1:0] A2_DEF = 12'sd0;

    localparam int DUTY_MIN_DEF    = 0;
    localparam int DUTY_MARGIN_DEF = 8;
    localparam int SLEW_MAX_DEF    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC0  = 3'd1,
        MAC1  = 3'd2,
        MAC2  = 3'd3,
        CLAMP = 3'd4
    } pid_state_t;

    // Sign-extend both operands by one bit; a disagreement between the two
    // top bits of the sum means the true result left the ACC_W range.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/duty_pid_compensator_clamp.sv
// ----------------------------------------------------------------------------
// duty_clamp
//   Combinational range clamp of a signed duty candidate against
//   [DUTY_MIN, maxcount - DUTY_MARGIN], plus an optional per-update slew
//   limit relative to the previous duty (macro DUTY_PID_SLEW_LIMIT_EN).
//   Ports:
//     cand      in  signed candidate duty (integer part of the accumulator)
//     maxcount  in  live DPWM period count
//     duty_prev in  currently applied duty (slew reference)
//     duty_out  out clamped duty
//     sat_hi    out candidate exceeded the upper limit
//     sat_lo    out candidate was below DUTY_MIN
//   The saturation flags describe the range clamp only, never the slew limit.
// ----------------------------------------------------------------------------
module duty_clamp
    import duty_pid_compensator_pkg::*;
#(
    parameter int DUTY_MIN    = DUTY_MIN_DEF,
    parameter int DUTY_MARGIN = DUTY_MARGIN_DEF,
    parameter int SLEW_MAX    = SLEW_MAX_DEF
) (
    input  logic signed [CAND_W-1:0] cand,
    input  logic        [DUTY_W-1:0] maxcount,
    input  logic        [DUTY_W-1:0] duty_prev,
    output logic        [DUTY_W-1:0] duty_out,
    output logic                     sat_hi,
    output logic                     sat_lo
);

    localparam logic [DUTY_W-1:0] MIN_D    = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] MARGIN_D = DUTY_W'(DUTY_MARGIN);
    localparam logic [DUTY_W-1:0] LIM_D    = DUTY_W'(DUTY_MIN + DUTY_MARGIN);

    logic [DUTY_W-1:0] hi_limit;
    logic [DUTY_W-1:0] range_duty;

    always_comb begin
        // A very short period would push the upper limit below the floor;
        // collapse the window onto DUTY_MIN instead.
        if (maxcount < LIM_D) begin
            hi_limit = MIN_D;
        end else begin
            hi_limit = maxcount - MARGIN_D;
        end
    end

    always_comb begin
        range_duty = cand[DUTY_W-1:0];
        sat_hi     = 1'b0;
        sat_lo     = 1'b0;
        if (cand > $signed({{(CAND_W-DUTY_W){1'b0}}, hi_limit})) begin
            range_duty = hi_limit;
            sat_hi     = 1'b1;
        end else if (cand < $signed({{(CAND_W-DUTY_W){1'b0}}, MIN_D})) begin
            range_duty = MIN_D;
            sat_lo     = 1'b1;
        end
    end

`ifdef DUTY_PID_SLEW_LIMIT_EN
    localparam logic signed [DUTY_W+1:0] SLEW_S = (DUTY_W+2)'(SLEW_MAX);

    logic signed [DUTY_W+1:0] prev_s;
    logic signed [DUTY_W+1:0] range_s;
    logic signed [DUTY_W+1:0] lim_s;

    always_comb begin
        prev_s  = $signed({2'b00, duty_prev});
        range_s = $signed({2'b00, range_duty});
        lim_s   = range_s;
        if (range_s - prev_s > SLEW_S) begin
            lim_s = prev_s + SLEW_S;
        end else if (range_s - prev_s < -SLEW_S) begin
            lim_s = prev_s - SLEW_S;
        end
        // The range window wins: a previous duty left outside a shrunken
        // window is pulled back in regardless of the slew step.
        if (lim_s > $signed({2'b00, hi_limit})) begin
            lim_s = $signed({2'b00, hi_limit});
        end else if (lim_s < $signed({2'b00, MIN_D})) begin
            lim_s = $signed({2'b00, MIN_D});
        end
        duty_out = lim_s[DUTY_W-1:0];
    end
`else
    logic unused_slew;
    assign unused_slew = (SLEW_MAX != 0) ^ (^duty_prev);
    assign duty_out    = range_duty;
`endif

endmodule

// File: rtl/duty_pid_compensator.sv
// ----------------------------------------------------------------------------
// duty_pid_compensator
//   Incremental 3-tap PID between the ADC error readout and the DPWM path:
//     u[n] = u[n-1] + A0*e[n] + A1*e[n-1] + A2*e[n-2]
//   One shared multiplier is stepped through MAC0..MAC2; CLAMP applies the
//   range (and optional slew) limit and updates history.
//   Optional feature macro: DUTY_PID_SLEW_LIMIT_EN (per-update slew limit).
//   Ports:
//     CLOCK_50   in  system clock
//     reset      in  asynchronous active-high reset
//     enable     in  loop closed when high
//     err        in  signed error sample, valid with err_valid
//     err_valid  in  single-cycle sample strobe
//     maxcount   in  live DPWM period count, sampled in CLAMP
//     duty_cmd   out duty count
//     duty_valid out single-cycle strobe on duty_cmd update
//     busy       out from accept through the duty_valid cycle
//     sat_hi     out last update clamped at the upper limit
//     sat_lo     out last update clamped at DUTY_MIN
//     overrun    out sticky: a sample arrived while busy
// ----------------------------------------------------------------------------
module duty_pid_compensator
    import duty_pid_compensator_pkg::*;
#(
    parameter logic signed [COEF_W-1:0] A0 = A0_DEF,
    parameter logic signed [COEF_W-1:0] A1 = A1_DEF,
    parameter logic signed [COEF_W-1:0] A2 = A2_DEF,
    parameter int DUTY_MIN    = DUTY_MIN_DEF,
    parameter int DUTY_MARGIN = DUTY_MARGIN_DEF,
    parameter int SLEW_MAX    = SLEW_MAX_DEF
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [ERR_W-1:0] err,
    input  logic                    err_valid,
    input  logic        [DUTY_W-1:0] maxcount,
    output logic        [DUTY_W-1:0] duty_cmd,
    output logic                    duty_valid,
    output logic                    busy,
    output logic                    sat_hi,
    output logic                    sat_lo,
    output logic                    overrun
);

    localparam logic [DUTY_W-1:0]       DUTY_RESET = DUTY_W'(DUTY_MIN);
    localparam logic signed [ACC_W-1:0] ACC_RESET  = ACC_W'(DUTY_MIN * (2 ** FRAC_BITS));

    pid_state_t state_reg, state_next;

    logic signed [ERR_W-1:0]  e0_reg, e1_reg, e2_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  accn_reg;
    logic        [DUTY_W-1:0] duty_reg;
    logic                     dv_reg;
    logic                     sat_hi_reg, sat_lo_reg;
    logic                     overrun_reg;

    logic                     accept;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [ERR_W-1:0]  samp_sel;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [CAND_W-1:0] cand;
    logic        [DUTY_W-1:0] clamp_duty;
    logic                     clamp_hi, clamp_lo;
    logic signed [ACC_W-1:0]  duty_as_acc;
    logic signed [ACC_W-1:0]  clamp_as_acc;
    logic                     cand_changed;

    // busy stays high through the duty_valid cycle, so the IDLE cycle that
    // carries duty_valid does not accept; a strobe there counts as overrun.
    assign busy   = (state_reg != IDLE) || dv_reg;
    assign accept = err_valid && enable && !busy;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MAC0;
            MAC0:    state_next = MAC1;
            MAC1:    state_next = MAC2;
            MAC2:    state_next = CLAMP;
            CLAMP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared multiplier: operands selected by the current MAC step.
    always_comb begin
        coef_sel = A0;
        samp_sel = e0_reg;
        case (state_reg)
            MAC1: begin
                coef_sel = A1;
                samp_sel = e1_reg;
            end
            MAC2: begin
                coef_sel = A2;
                samp_sel = e2_reg;
            end
            default: ;
        endcase
        product = PROD_W'(coef_sel) * PROD_W'(samp_sel);
        mac_sum = sat_add((state_reg == MAC0) ? acc_reg : accn_reg, ACC_W'(product));
    end

    // Integer part of acc_n; dropping the fraction bits is an arithmetic
    // shift that truncates toward -inf.
    assign cand = accn_reg[ACC_W-1:FRAC_BITS];

    duty_clamp #(
        .DUTY_MIN    (DUTY_MIN),
        .DUTY_MARGIN (DUTY_MARGIN),
        .SLEW_MAX    (SLEW_MAX)
    ) u_clamp (
        .cand      (cand),
        .maxcount  (maxcount),
        .duty_prev (duty_reg),
        .duty_out  (clamp_duty),
        .sat_hi    (clamp_hi),
        .sat_lo    (clamp_lo)
    );

    assign duty_as_acc  = $signed({{(ACC_W-DUTY_W-FRAC_BITS){1'b0}}, duty_reg, {FRAC_BITS{1'b0}}});
    assign clamp_as_acc = $signed({{(ACC_W-DUTY_W-FRAC_BITS){1'b0}}, clamp_duty, {FRAC_BITS{1'b0}}});
    // Any limiting (range or slew) means acc must follow the applied duty so
    // the integrator never winds up past what the plant actually sees.
    assign cand_changed = ($signed({{(CAND_W-DUTY_W){1'b0}}, clamp_duty}) != cand);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            e0_reg      <= '0;
            e1_reg      <= '0;
            e2_reg      <= '0;
            acc_reg     <= ACC_RESET;
            accn_reg    <= '0;
            duty_reg    <= DUTY_RESET;
            dv_reg      <= 1'b0;
            sat_hi_reg  <= 1'b0;
            sat_lo_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dv_reg    <= 1'b0;
            if (err_valid && busy) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (!enable) begin
                        // Open loop: forget history and resume bumplessly
                        // from the duty currently being applied.
                        e1_reg  <= '0;
                        e2_reg  <= '0;
                        acc_reg <= duty_as_acc;
                    end else if (accept) begin
                        e0_reg <= err;
                    end
                end
                MAC0, MAC1, MAC2: begin
                    accn_reg <= mac_sum;
                end
                CLAMP: begin
                    duty_reg   <= clamp_duty;
                    sat_hi_reg <= clamp_hi;
                    sat_lo_reg <= clamp_lo;
                    acc_reg    <= cand_changed ? clamp_as_acc : accn_reg;
                    e2_reg     <= e1_reg;
                    e1_reg     <= e0_reg;
                    dv_reg     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign duty_cmd   = duty_reg;
    assign duty_valid = dv_reg;
    assign sat_hi     = sat_hi_reg;
    assign sat_lo     = sat_lo_reg;
    assign overrun    = overrun_reg;

endmodule
